// File: rtl/siso_exchange_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : siso_exchange_ctrl
// Purpose  : Drives an external N-stage serial-in/serial-out flop chain as a
//            full-duplex word exchanger. A parallel word accepted on the input
//            handshake is shifted LSB-first into the chain. The N bits that
//            fall out of the chain's tail are collected at the same time and
//            offered on the output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module siso_exchange_ctrl #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [N-1:0] I_DATA,
    input  logic         I_VALID,
    output logic         I_READY,
    input  logic         HOLD,
    output logic         SO,
    output logic         CE,
    input  logic         SI,
    output logic [N-1:0] O_DATA,
    output logic         O_VALID,
    input  logic         O_READY,
    output logic         BUSY
);

    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         state_q;
    logic [N-1:0]   tx_q;
    logic [N-1:0]   rx_q;
    logic [CW-1:0]  count_q;
    logic           i_ready_q;
    logic           o_valid_q;
    logic           busy_q;

    // Controller FSM: state, shift registers, counter and handshake flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            count_q   <= '0;
            i_ready_q <= 1'b1;
            o_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_VALID) begin
                        tx_q      <= I_DATA;
                        count_q   <= '0;
                        state_q   <= S_SHIFT;
                        i_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // The chain only moves when HOLD is low, so the capture
                    // of its tail bit is gated identically.
                    if (!HOLD) begin
                        tx_q <= tx_q >> 1;
                        rx_q <= {SI, rx_q[N-1:1]};
                        if (count_q == LAST) begin
                            count_q   <= '0;
                            state_q   <= S_DONE;
                            o_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (O_READY) begin
                        state_q   <= S_IDLE;
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    i_ready_q <= 1'b1;
                    o_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Chain drive: the shift enable reacts to HOLD in the same cycle
    always_comb begin
        CE = (state_q == S_SHIFT) && !HOLD;
        SO = (state_q == S_SHIFT) ? tx_q[0] : 1'b0;
    end

    assign I_READY = i_ready_q;
    assign O_VALID = o_valid_q;
    assign BUSY    = busy_q;
    assign O_DATA  = rx_q;

endmodule
`default_nettype wire

// File: tb/tb_siso_exchange_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_siso_exchange_ctrl
// Purpose  : Directed bench for siso_exchange_ctrl with a behavioural model of
//            the external 8-stage CE-gated flop chain (power-up contents 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_siso_exchange_ctrl;

    localparam int N = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [N-1:0] I_DATA = '0;
    logic         I_VALID = 1'b0;
    logic         I_READY;
    logic         HOLD = 1'b0;
    logic         SO;
    logic         CE;
    logic         SI;
    logic [N-1:0] O_DATA;
    logic         O_VALID;
    logic         O_READY = 1'b0;
    logic         BUSY;

    // External shift chain: stage 0 takes SO, the tail feeds SI
    logic [N-1:0] chain = '0;

    int compared   = 0;
    int mismatched = 0;

    siso_exchange_ctrl #(.N(N)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I_DATA  (I_DATA),
        .I_VALID (I_VALID),
        .I_READY (I_READY),
        .HOLD    (HOLD),
        .SO      (SO),
        .CE      (CE),
        .SI      (SI),
        .O_DATA  (O_DATA),
        .O_VALID (O_VALID),
        .O_READY (O_READY),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    // Chain model: shifts toward the tail on every enabled edge
    always @(posedge CLK) begin
        if (CE) chain <= {chain[N-2:0], SO};
    end
    assign SI = chain[N-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full exchange. Inputs are driven just after the falling edge and
    // outputs checked 1 time unit later, well away from the rising edge.
    // hs/hl: HOLD is raised for hl cycles once hs enabled shifts have occurred.
    // ord  : number of DONE cycles with O_READY low before the handshake.
    task automatic xchg(input logic [7:0] d, input int hs, input int hl, input int ord,
                        input bit chk_out, input logic [7:0] expo,
                        input bit stall_valid, input logic [7:0] stall_data);
        int          ces;
        int          held;
        int          cyc;
        bit          done;
        logic [7:0]  so_bits;
        logic [7:0]  first_out;
        ces = 0; held = 0; cyc = 0; done = 1'b0; so_bits = '0;

        @(negedge CLK);
        I_DATA = d; I_VALID = 1'b1; O_READY = 1'b0; HOLD = 1'b0;
        #1;
        chk("accept_ready", I_READY, 1);
        chk("idle_ce", CE, 0);

        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            I_VALID = 1'b0;
            HOLD = (ces == hs) && (held < hl);
            #1;
            if (O_VALID) begin
                done = 1'b1;
                break;
            end
            if (i == 0) begin
                chk("shift_iready", I_READY, 0);
                chk("shift_busy", BUSY, 1);
            end
            if (CE) begin
                so_bits[ces] = SO;
                ces++;
            end else begin
                held++;
            end
            cyc++;
        end
        HOLD = 1'b0;
        chk("done_reached", done, 1);
        chk("ce_count", ces, 8);
        chk("shift_cycles", cyc, 8 + hl);
        chk("so_sequence", so_bits, d);
        chk("done_iready", I_READY, 0);
        chk("done_busy", BUSY, 1);
        if (chk_out) chk("o_data", O_DATA, expo);
        first_out = O_DATA;
        O_READY = (ord == 0);

        for (int k = 1; k <= ord; k++) begin
            @(negedge CLK);
            if (stall_valid) begin
                I_DATA = stall_data; I_VALID = 1'b1;
            end
            #1;
            chk("stall_ovalid", O_VALID, 1);
            chk("stall_odata", O_DATA, first_out);
            chk("stall_iready", I_READY, 0);
            chk("stall_ce", CE, 0);
            if (k == ord) O_READY = 1'b1;
        end

        @(negedge CLK);
        O_READY = 1'b0; I_VALID = 1'b0;
        #1;
        chk("post_ovalid", O_VALID, 0);
        chk("post_iready", I_READY, 1);
        chk("post_busy", BUSY, 0);
    endtask

    logic [7:0] prev;
    logic [7:0] w;

    initial begin
        // Power-up reset
        RESET = 1'b1;
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_iready", I_READY, 1);
        chk("rst_ce", CE, 0);
        chk("rst_so", SO, 0);
        chk("rst_ovalid", O_VALID, 0);
        chk("rst_odata", O_DATA, 0);
        chk("rst_busy", BUSY, 0);

        // First exchange returns the chain's initial zeros
        xchg(8'hA5, 0, 0, 0, 1'b1, 8'h00, 1'b0, 8'h00);
        // Back-to-back words: each returns its predecessor
        xchg(8'h3C, 0, 0, 0, 1'b1, 8'hA5, 1'b0, 8'h00);
        xchg(8'hFF, 0, 0, 0, 1'b1, 8'h3C, 1'b0, 8'h00);
        xchg(8'h00, 0, 0, 0, 1'b1, 8'hFF, 1'b0, 8'h00);
        // HOLD for 3 cycles after the 4th shift
        xchg(8'h81, 4, 3, 0, 1'b1, 8'h00, 1'b0, 8'h00);
        // Output backpressure for 5 cycles while a new word waits
        xchg(8'h42, 0, 0, 5, 1'b1, 8'h81, 1'b1, 8'h55);
        xchg(8'h55, 0, 0, 0, 1'b1, 8'h42, 1'b0, 8'h00);

        // Reset on the 3rd shift cycle
        @(negedge CLK);
        I_DATA = 8'h99; I_VALID = 1'b1;
        @(negedge CLK);
        I_VALID = 1'b0;
        #1;
        chk("abort_ce1", CE, 1);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("mrst_iready", I_READY, 1);
        chk("mrst_ce", CE, 0);
        chk("mrst_ovalid", O_VALID, 0);
        chk("mrst_odata", O_DATA, 0);
        chk("mrst_busy", BUSY, 0);
        // Dummy exchange re-primes the chain; its output is not meaningful
        xchg(8'h12, 0, 0, 0, 1'b0, 8'h00, 1'b0, 8'h00);
        xchg(8'h34, 0, 0, 0, 1'b1, 8'h12, 1'b0, 8'h00);

        // Randomised traffic: idle gaps, HOLD bursts, backpressure
        prev = 8'h34;
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                I_VALID = 1'b0;
                I_DATA = 8'($urandom);
            end
            w = 8'($urandom);
            xchg(w, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'b1, prev, 1'b0, 8'h00);
            prev = w;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
